// File: rtl/matrix_input_loader_pkg.sv
// loader_pkg: FSM state encoding and stream/line sizing helpers for matrix_input_loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT_RDY, RUN} state_t;
  function automatic int wpl(input int mem_port_width, input int word_size);
    return mem_port_width / word_size;
  endfunction
  function automatic int total(input int rows, input int cols);
    return 2 * rows * cols;
  endfunction
  function automatic int lines(input int words, input int per_line);
    return (words + per_line - 1) / per_line;
  endfunction
endpackage

// File: rtl/matrix_input_loader_if.sv
// matrix_input_loader_if: host word stream plus input-RAM write port.
interface matrix_input_loader_if #(parameter int WORD_SIZE = 8, parameter int MEM_PORT_WIDTH = 32);
  logic [WORD_SIZE-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [31:0] mem_addr;
  logic [MEM_PORT_WIDTH-1:0] mem_wr_data;
  logic mem_wr_en;
  modport master(output s_data, s_valid, input s_ready, mem_addr, mem_wr_data, mem_wr_en);
  modport slave(input s_data, s_valid, output s_ready, mem_addr, mem_wr_data, mem_wr_en);
endinterface

// File: rtl/matrix_input_loader_word_line_packer.sv
// word_line_packer: places words LSB-first into a RAM line and emits it when full or flushed.
module word_line_packer import loader_pkg::*; #(
  parameter int WORD_SIZE = 8,
  parameter int MEM_PORT_WIDTH = 32,
  localparam int WPL = wpl(MEM_PORT_WIDTH, WORD_SIZE),
  localparam int CW = $clog2(WPL + 1)
) (
  input logic clk,
  input logic rst,
  input logic [WORD_SIZE-1:0] word,
  input logic shift,
  input logic flush,
  input logic clear,
  output logic [MEM_PORT_WIDTH-1:0] line,
  output logic line_valid,
  output logic [CW-1:0] slots
);
  logic [MEM_PORT_WIDTH-1:0] pack, fill;
  logic emit;
  always_comb begin
    fill = pack;
    for (int i = 0; i < WPL; i++)
      if (slots == CW'(i)) fill[i*WORD_SIZE +: WORD_SIZE] = word;
  end
  assign emit = shift && (flush || slots == CW'(WPL - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pack <= '0;
      slots <= '0;
      line <= '0;
      line_valid <= 1'b0;
    end else begin
      line_valid <= emit;
      if (emit) line <= fill;
      if (clear) begin
        pack <= '0;
        slots <= '0;
      end else if (shift) begin
        pack <= emit ? '0 : fill;
        slots <= emit ? '0 : slots + 1'b1;
      end
    end
endmodule

// File: rtl/matrix_input_loader.sv
// matrix_input_loader: packs the host operand stream into input RAM, then sequences the matmul start.
// Define LOADER_CHECKSUM_EN to add an XOR checksum of the accepted words.
module matrix_input_loader import loader_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int WORD_SIZE = 8,
  parameter int MEM_PORT_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR = '0
) (
  input logic clk,
  input logic rst,
  input logic load_start,
  input logic fsm_rdy,
  input logic matmul_done,
  matrix_input_loader_if.slave bus,
  output logic inputs_rdy,
  output logic start_fsm,
  output logic start_matmul,
  output logic loader_busy,
  output logic err_overrun
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [WORD_SIZE-1:0] checksum,
  output logic checksum_valid
`endif
);
  localparam int TOTAL = total(ROWS, COLS);
  localparam int WPL = wpl(MEM_PORT_WIDTH, WORD_SIZE);
  localparam int CW = $clog2(WPL + 1);
  localparam int NW = $clog2(TOTAL + 1);
  state_t st, nxt;
  logic [NW-1:0] wcnt;
  logic [CW-1:0] slots;
  logic [31:0] addr;
  logic [MEM_PORT_WIDTH-1:0] line;
  logic go, hs, last, lv;
  assign go = load_start && st == IDLE;
  assign hs = bus.s_valid && st == LOAD;
  assign last = hs && wcnt == NW'(TOTAL - 1);
  assign bus.s_ready = st == LOAD;
  assign bus.mem_addr = addr;
  assign bus.mem_wr_data = line;
  assign bus.mem_wr_en = lv;
  assign start_fsm = st == START;
  assign loader_busy = st != IDLE;
  word_line_packer #(.WORD_SIZE(WORD_SIZE), .MEM_PORT_WIDTH(MEM_PORT_WIDTH)) u_pack (
    .clk(clk), .rst(rst), .word(bus.s_data), .shift(hs), .flush(last), .clear(go),
    .line(line), .line_valid(lv), .slots(slots)
  );
  always_comb begin
    nxt = st;
    case (st)
      IDLE:     if (load_start) nxt = LOAD;
      // a last word landing in the final slot completes the line itself; otherwise pad it out
      LOAD:     if (last) nxt = (slots == CW'(WPL - 1)) ? START : FLUSH;
      FLUSH:    nxt = START;
      START:    nxt = WAIT_RDY;
      WAIT_RDY: if (fsm_rdy) nxt = RUN;
      RUN:      if (matmul_done) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      wcnt <= '0;
      addr <= BASE_ADDR;
      inputs_rdy <= 1'b0;
      start_matmul <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      st <= nxt;
      wcnt <= go ? '0 : wcnt + NW'(hs);
      addr <= go ? BASE_ADDR : addr + 32'(lv);
      inputs_rdy <= go ? 1'b0 : inputs_rdy | (nxt == START);
      start_matmul <= st == WAIT_RDY && fsm_rdy;
      err_overrun <= err_overrun | (load_start && st != IDLE);
    end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      checksum <= '0;
      checksum_valid <= 1'b0;
    end else begin
      checksum <= go ? '0 : hs ? checksum ^ bus.s_data : checksum;
      checksum_valid <= go ? 1'b0 : checksum_valid | (nxt == START);
    end
`endif
endmodule

// File: tb/tb_matrix_input_loader.sv
// tb_matrix_input_loader: random-stimulus bench against a line/address model for 32- and 24-bit lines.
module tb_matrix_input_loader;
  logic clk = 0, rst = 1, load_start = 0, s_valid = 0, fsm_rdy = 0, matmul_done = 0;
  logic [7:0] s_data = 0;
  logic ir_a, sf_a, sm_a, busy_a, err_a, ir_b, sf_b, sm_b, busy_b, err_b;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] cs_a, cs_b;
  logic csv_a, csv_b;
`endif
  int errors = 0, checks = 0, cyc = 0, rise_cyc = 0;
  logic [7:0] w [32];
  bit rdy_drop;
  int wa_addr[$], wa_cyc[$], wb_addr[$], wb_cyc[$], ea_cyc[$], eb_cyc[$];
  logic [31:0] wa_data[$];
  logic [23:0] wb_data[$];
  int sf_cnt_a, sf_cyc_a, sm_cnt_a, sm_cyc_a, sf_cnt_b, sm_cnt_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_input_loader_if #(.WORD_SIZE(8), .MEM_PORT_WIDTH(32)) bus_a();
  matrix_input_loader_if #(.WORD_SIZE(8), .MEM_PORT_WIDTH(24)) bus_b();
  assign bus_a.s_data = s_data;
  assign bus_a.s_valid = s_valid;
  assign bus_b.s_data = s_data;
  assign bus_b.s_valid = s_valid;

  matrix_input_loader #(.MEM_PORT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .fsm_rdy(fsm_rdy), .matmul_done(matmul_done),
    .bus(bus_a), .inputs_rdy(ir_a), .start_fsm(sf_a), .start_matmul(sm_a),
    .loader_busy(busy_a), .err_overrun(err_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cs_a), .checksum_valid(csv_a)
`endif
  );
  matrix_input_loader #(.MEM_PORT_WIDTH(24)) dut24 (
    .clk(clk), .rst(rst), .load_start(load_start), .fsm_rdy(fsm_rdy), .matmul_done(matmul_done),
    .bus(bus_b), .inputs_rdy(ir_b), .start_fsm(sf_b), .start_matmul(sm_b),
    .loader_busy(busy_b), .err_overrun(err_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cs_b), .checksum_valid(csv_b)
`endif
  );

  always @(negedge clk) begin
    if (bus_a.mem_wr_en) begin
      wa_addr.push_back(int'(bus_a.mem_addr));
      wa_data.push_back(bus_a.mem_wr_data);
      wa_cyc.push_back(cyc);
    end
    if (bus_b.mem_wr_en) begin
      wb_addr.push_back(int'(bus_b.mem_addr));
      wb_data.push_back(bus_b.mem_wr_data);
      wb_cyc.push_back(cyc);
    end
    if (sf_a) begin sf_cnt_a++; sf_cyc_a = cyc; end
    if (sm_a) begin sm_cnt_a++; sm_cyc_a = cyc; end
    if (sf_b) sf_cnt_b++;
    if (sm_b) sm_cnt_b++;
  end

  task automatic clear_logs();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete(); ea_cyc.delete();
    wb_addr.delete(); wb_data.delete(); wb_cyc.delete(); eb_cyc.delete();
    sf_cnt_a = 0; sm_cnt_a = 0; sf_cnt_b = 0; sm_cnt_b = 0;
  endtask

  task automatic run_load(input bit bub, input int ovr, input int stop);
    int n = 0, g = 0;
    bit v;
    rdy_drop = 0;
    @(negedge clk) load_start = 1;
    @(negedge clk) load_start = 0;
    while (n < stop && g < 2000) begin
      v = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v;
      s_data = v ? w[n] : 8'($urandom);
      load_start = (n == ovr);
      if (!bus_a.s_ready || !bus_b.s_ready) rdy_drop = 1;
      @(negedge clk);
      g++;
      if (v) begin
        if ((n + 1) % 4 == 0 || n == 31) ea_cyc.push_back(cyc);
        if ((n + 1) % 3 == 0 || n == 31) eb_cyc.push_back(cyc);
        n++;
      end
    end
    s_valid = 0;
    load_start = 0;
    checks++;
    if (n != stop) begin errors++; $display("FAIL load_timeout words=%0d want=%0d", n, stop); end
  endtask

  task automatic finish_run(input int delay);
    int g = 0;
    while ((sf_cnt_a == 0 || sf_cnt_b == 0) && g < 50) begin @(negedge clk); g++; end
    repeat (delay) @(negedge clk);
    fsm_rdy = 1;
    rise_cyc = cyc;
    g = 0;
    while ((sm_cnt_a == 0 || sm_cnt_b == 0) && g < 50) begin @(negedge clk); g++; end
    checks++;
    if (sm_cnt_a == 0 || sm_cnt_b == 0) begin
      errors++; $display("FAIL start_timeout sm_a=%0d sm_b=%0d want>=1", sm_cnt_a, sm_cnt_b);
    end
    @(negedge clk) matmul_done = 1;
    @(negedge clk) matmul_done = 0;
    fsm_rdy = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.s_ready, bus_a.mem_wr_en, ir_a, sf_a, sm_a, busy_a, err_a} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl got=%b want=0000000", {bus_a.s_ready, bus_a.mem_wr_en, ir_a, sf_a, sm_a, busy_a, err_a}); end
    checks++;
    if (bus_a.mem_addr !== 32'd0 || bus_a.mem_wr_data !== 32'd0)
      begin errors++; $display("FAIL reset_bus addr=%h data=%h want 0", bus_a.mem_addr, bus_a.mem_wr_data); end
    checks++;
    if (busy_b !== 1'b0 || bus_b.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_b busy=%b en=%b want 0", busy_b, bus_b.mem_wr_en); end
    rst = 0;
  endtask

  task automatic test_load(input string nm, input bit bub, input int ovr);
    logic [31:0] e;
    clear_logs();
    run_load(bub, ovr, 32);
    checks++;
    if (bus_a.s_ready !== 1'b0 || bus_b.s_ready !== 1'b0)
      begin errors++; $display("FAIL %s ready_after_last a=%b b=%b want 0", nm, bus_a.s_ready, bus_b.s_ready); end
    checks++;
    if (rdy_drop) begin errors++; $display("FAIL %s ready_drop got=1 want=0", nm); end
    checks++;
    if (err_a !== (ovr >= 0)) begin errors++; $display("FAIL %s err_overrun got=%b want=%b", nm, err_a, ovr >= 0); end
    finish_run(2);
    checks++;
    if (wa_addr.size() != 8 || ea_cyc.size() != 8)
      begin errors++; $display("FAIL %s a_writes got=%0d want=8", nm, wa_addr.size()); end
    else for (int j = 0; j < 8; j++) begin
      e = 0;
      for (int k = 0; k < 4; k++) e[8*k +: 8] = w[j*4+k];
      checks++;
      if (wa_addr[j] !== j || wa_data[j] !== e || wa_cyc[j] !== ea_cyc[j]) begin
        errors++;
        $display("FAIL %s a_line%0d addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d", nm, j, wa_addr[j], wa_data[j], wa_cyc[j], j, e, ea_cyc[j]);
      end
    end
    checks++;
    if (wb_addr.size() != 11 || eb_cyc.size() != 11)
      begin errors++; $display("FAIL %s b_writes got=%0d want=11", nm, wb_addr.size()); end
    else for (int j = 0; j < 11; j++) begin
      e = 0;
      for (int k = 0; k < 3; k++) if (j*3 + k < 32) e[8*k +: 8] = w[j*3+k];
      checks++;
      if (wb_addr[j] !== j || wb_data[j] !== e[23:0] || wb_cyc[j] !== eb_cyc[j]) begin
        errors++;
        $display("FAIL %s b_line%0d addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d", nm, j, wb_addr[j], wb_data[j], wb_cyc[j], j, e[23:0], eb_cyc[j]);
      end
    end
    checks++;
    if (sf_cnt_a != 1 || sm_cnt_a != 1 || sf_cnt_b != 1 || sm_cnt_b != 1)
      begin errors++; $display("FAIL %s pulses sf=%0d/%0d sm=%0d/%0d want 1", nm, sf_cnt_a, sf_cnt_b, sm_cnt_a, sm_cnt_b); end
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || ir_a !== 1'b1 || ir_b !== 1'b1)
      begin errors++; $display("FAIL %s done_state busy=%b%b rdy=%b%b want 00 11", nm, busy_a, busy_b, ir_a, ir_b); end
  endtask

  task automatic test_start_handshake();
    int g = 0;
    for (int i = 0; i < 32; i++) w[i] = 8'($urandom);
    clear_logs();
    run_load(0, -1, 32);
    while (sf_cnt_a == 0 && g < 50) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    matmul_done = 1;
    @(negedge clk) matmul_done = 0;
    checks++;
    if (busy_a !== 1'b1 || sm_cnt_a != 0) begin errors++; $display("FAIL early_done busy=%b sm=%0d want 1 0", busy_a, sm_cnt_a); end
    repeat (2) @(negedge clk);
    fsm_rdy = 1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    checks++;
    if (sm_cnt_a != 1 || sm_cyc_a != rise_cyc + 1)
      begin errors++; $display("FAIL sm_delayed cnt=%0d cyc=%0d want 1 %0d", sm_cnt_a, sm_cyc_a, rise_cyc + 1); end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL run_busy got=%b want=1", busy_a); end
    @(negedge clk) matmul_done = 1;
    @(negedge clk) matmul_done = 0;
    checks++;
    if (busy_a !== 1'b0 || ir_a !== 1'b1) begin errors++; $display("FAIL run_done busy=%b rdy=%b want 0 1", busy_a, ir_a); end
    clear_logs();
    run_load(0, -1, 32);
    repeat (6) @(negedge clk);
    checks++;
    if (sm_cnt_a != 1 || sm_cyc_a != sf_cyc_a + 2)
      begin errors++; $display("FAIL sm_rdy_high cnt=%0d cyc=%0d want 1 %0d", sm_cnt_a, sm_cyc_a, sf_cyc_a + 2); end
    @(negedge clk) matmul_done = 1;
    @(negedge clk) matmul_done = 0;
    fsm_rdy = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 32; i++) w[i] = 8'($urandom);
    clear_logs();
    run_load(0, -1, 10);
    rst = 1;
    #1;
    checks++;
    if ({bus_a.s_ready, bus_a.mem_wr_en, ir_a, sf_a, sm_a, busy_a, err_a} !== 7'b0)
      begin errors++; $display("FAIL midrst_ctrl got=%b want=0000000", {bus_a.s_ready, bus_a.mem_wr_en, ir_a, sf_a, sm_a, busy_a, err_a}); end
    checks++;
    if (bus_a.mem_addr !== 32'd0 || bus_a.mem_wr_data !== 32'd0)
      begin errors++; $display("FAIL midrst_bus addr=%h data=%h want 0", bus_a.mem_addr, bus_a.mem_wr_data); end
    @(negedge clk) rst = 0;
    for (int i = 0; i < 32; i++) w[i] = 8'($urandom);
    test_load("after_rst", 0, -1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] x;
    for (int p = 0; p < 3; p++) begin
      x = 0;
      for (int i = 0; i < 32; i++) begin
        w[i] = (p == 0) ? 8'(i) : (p == 2 && i == 31) ? 8'd2 : 8'd1;
        x = x ^ w[i];
      end
      clear_logs();
      run_load(0, -1, 32);
      checks++;
      if (cs_a !== x || csv_a !== 1'b1)
        begin errors++; $display("FAIL checksum%0d got=%h valid=%b want=%h 1", p, cs_a, csv_a, x); end
      finish_run(1);
    end
  endtask
`endif

  initial begin
    test_reset();
    for (int i = 0; i < 32; i++) w[i] = 8'(i);
    test_load("full_lines", 0, -1);
    for (int i = 0; i < 32; i++) w[i] = 8'($urandom);
    test_load("bubbles", 1, -1);
    test_start_handshake();
    for (int i = 0; i < 32; i++) w[i] = 8'($urandom);
    test_load("overrun", 0, 5);
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_input_loader.md
Name: matrix_input_loader

Overview:
- Upstream of the systolic top. Accepts the operand matrices as a host word stream, packs them into input-RAM lines and writes them into input RAM.
- Then sequences the top's `inputs_rdy`, `start_fsm` and `start_matmul` controls.
- Holds off new loads until the matmul reports completion, so input RAM is never overwritten mid-run.

Parameters:
- ROWS, 4, systolic rows.
- COLS, 4, systolic cols.
- WORD_SIZE, 8, bits per matrix element.
- MEM_PORT_WIDTH, 32, input-RAM line width; must be a multiple of WORD_SIZE.
- BASE_ADDR, 0, first input-RAM address written.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  pulse; begin a load (honoured only in IDLE).
- s_data  in  WORD_SIZE  host word.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts word.
- mem_addr  out  32  input-RAM write address.
- mem_wr_data  out  MEM_PORT_WIDTH  packed line.
- mem_wr_en  out  1  write strobe.
- inputs_rdy  out  1  matrices resident in RAM.
- start_fsm  out  1  one-cycle pulse to the matmul FSM.
- start_matmul  out  1  one-cycle pulse to the matmul FSM.
- fsm_rdy  in  1  matmul FSM ready for start_matmul.
- matmul_done  in  1  pulse; output RAM write-back finished.
- loader_busy  out  1  high in any state except IDLE.
- err_overrun  out  1  sticky; load_start seen while busy.

Behaviour:
- Constants:
  - WPL = MEM_PORT_WIDTH/WORD_SIZE.
  - TOTAL = 2*ROWS*COLS words: top matrix row-major, then left matrix row-major.
  - LINES = ceil(TOTAL/WPL).
- Reset values: all outputs 0, state IDLE, counters 0, pack register 0, mem_addr = BASE_ADDR.
- Packing:
  - Word k of a line occupies bits [k*WORD_SIZE +: WORD_SIZE], so the first word received sits in the LSBs.
  - A line is written when WPL words have been collected, or at the end of the stream. Unfilled slots are zero.
- FSM states and transitions:
  - IDLE: s_ready=0. On load_start, clear counters, set mem_addr=BASE_ADDR, drop inputs_rdy, go to LOAD.
  - LOAD: s_ready=1.
    - Each handshake (s_valid&&s_ready) shifts the word into the pack register.
    - On the WPL-th word of a line: in the next cycle mem_wr_en=1, mem_wr_data=the line, mem_addr=current line address. The address then increments. Write latency is 1 cycle after the completing handshake.
    - Back-to-back words are accepted with no bubbles; the line write overlaps acceptance of the next line.
    - After the TOTAL-th word: go to FLUSH if the last line is partial, otherwise go to START.
  - FLUSH: s_ready=0. Write the zero-padded partial line for one cycle, then go to START.
  - START: s_ready=0. Set inputs_rdy=1; pulse start_fsm for exactly one cycle; go to WAIT_RDY.
  - WAIT_RDY: wait for fsm_rdy=1. Pulse start_matmul for one cycle in the cycle after fsm_rdy is first sampled high, then go to RUN.
  - RUN: on matmul_done, go to IDLE. inputs_rdy stays 1 until the next load_start.
- Boundaries and simultaneous events:
  - s_valid=0 mid-line: the pack register holds; no write occurs.
  - load_start outside IDLE is ignored, and err_overrun is set (sticky until rst).
  - matmul_done outside RUN is ignored.
  - fsm_rdy already high on entry to WAIT_RDY: start_matmul fires on the next cycle.
  - Address arithmetic: 32-bit, wraps modulo 2^32 with no flag.
  - The word count never exceeds TOTAL; s_ready drops in the cycle after the TOTAL-th handshake.
  - Reset asserted mid-operation: immediate return to IDLE with all outputs 0. Partially written RAM contents are not invalidated, but inputs_rdy=0 marks them stale.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - Extra outputs `checksum[WORD_SIZE-1:0]` (XOR of every accepted word) and `checksum_valid` (high from START until the next load_start).
  - Checksum clears on load_start.
- Disabled: neither port nor logic exists; behaviour is otherwise identical.

Decomposition:
- Package `loader_pkg`:
  - state enum {IDLE, LOAD, FLUSH, START, WAIT_RDY, RUN};
  - WPL, TOTAL and LINES helper functions or localparams derived from the parameters.
- Sub-module `word_line_packer`:
  - inputs: word, shift strobe, flush, clear;
  - outputs: line, line_valid pulse, slot count.
- The FSM, address counter and start sequencing stay in the top of this block.

Test Plan:
- Full lines (ROWS=COLS=4, WORD_SIZE=8, MEM_PORT_WIDTH=32): stream words 0x00..0x1F back-to-back.
  - Expect 8 writes at addresses 0..7, first line 0x03020100 and last 0x1F1E1D1C, then start_fsm pulse; s_ready never drops before word 32.
- Partial last line (MEM_PORT_WIDTH=24, same stream):
  - Expect 11 writes; the last write is 0x00001F1E via FLUSH.
- Bubbles: random s_valid gaps at 50% density.
  - Expect identical RAM image and address sequence; no write on gap cycles.
- Start handshake:
  - fsm_rdy held low 5 cycles after start_fsm → start_matmul pulses exactly once, 1 cycle after fsm_rdy rises.
  - matmul_done → IDLE, loader_busy=0.
- Overrun and reset:
  - load_start during LOAD → err_overrun=1, load continues unaffected.
  - rst asserted after word 10 → all outputs 0 immediately; a new load starts from BASE_ADDR.
- LOADER_CHECKSUM_EN build, words 0x00..0x1F:
  - checksum=0x00 with checksum_valid=1 from START.
  - Reload with words all 0x01 → checksum=0x00; with 31 words 0x01 and the last word 0x02 → 0x03.
